transmitter_datapath: RTL and testbench

UART transmit datapath paired with `transmitter_control`. It holds the baud-period counter, the data-bit counter and the 8-bit shift register, and drives the serial line. It produces `o_equal` (end of a bit period) and `o_equal_MSB` (last data bit in progress), which the control FSM consumes. It also consumes the control FSM's one-hot state flags to decide what to count, load, shift and drive onto the line.

---
 rtl/transmitter_datapath.sv | 84 ++++++++
 tb/tb_transmitter_datapath.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/transmitter_datapath.sv
// UART transmit datapath: baud counter, data-bit counter, shift register and
// serial line driver, steered by the one-hot state flags of transmitter_control.
module transmitter_datapath #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_state_is_START,
    input  logic       i_state_is_DATA,
    input  logic       i_state_is_STOP,
    input  logic [7:0] i_data,
    output logic       o_equal,
    output logic       o_equal_MSB,
    output logic       o_tx,
    output logic       o_busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          start, data, stop, active;

    // Resolve illegal multi-flag combinations: START wins over DATA over STOP.
    always_comb begin
        start  = i_state_is_START;
        data   = i_state_is_DATA & ~i_state_is_START;
        stop   = i_state_is_STOP & ~i_state_is_START & ~i_state_is_DATA;
        active = start | data | stop;
    end

    // End-of-bit and last-data-bit decodes; only registers and flags feed these.
    always_comb begin
        o_equal     = active && (baud_cnt == LAST);
        o_equal_MSB = data && (bit_idx == 3'd7);
    end

    // Baud counter: free-runs while active, wraps on the bit boundary.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            baud_cnt <= '0;
        else if (!active || o_equal)
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + CW'(1);
    end

    // Data-bit index: advances once per data bit; 7 -> 0 wrap is natural.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            bit_idx <= 3'd0;
        else if (!data)
            bit_idx <= 3'd0;
        else if (o_equal)
            bit_idx <= bit_idx + 3'd1;
    end

    // Shift register: load on first START cycle, shift LSB-first during DATA.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            shreg <= 8'h00;
        else if (start && baud_cnt == '0)
            shreg <= i_data;
        else if (data && o_equal)
            shreg <= {1'b1, shreg[7:1]};
    end

    // Serial line and busy, both one clock behind the flags.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
        end else begin
            o_busy <= active;
            if (start)
                o_tx <= 1'b0;
            else if (data)
                o_tx <= shreg[0];
            else
                o_tx <= 1'b1;
        end
    end
endmodule

// File: tb/tb_transmitter_datapath.sv
// Self-checking bench for transmitter_datapath at CLKS_PER_BIT 16 and 2.
// The bench plays the control FSM by counting whole bit periods itself and
// predicts the line from the frame description (start, 8 data LSB first, stop).
module tb_transmitter_datapath;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] f16 = 3'b000, f2 = 3'b000;   // {stop, data, start}
    logic [7:0] d16 = 8'h00, d2 = 8'h00;
    logic       eq16, msb16, tx16, busy16;
    logic       eq2, msb2, tx2, busy2;

    int  n_chk = 0, n_pass = 0;
    bit  cur = 1'b0;       // 0: CPB=16 instance, 1: CPB=2 instance
    logic last_tx = 1'b1, last_busy = 1'b0;

    logic s_eq, s_msb, s_tx, s_busy;
    assign s_eq   = cur ? eq2   : eq16;
    assign s_msb  = cur ? msb2  : msb16;
    assign s_tx   = cur ? tx2   : tx16;
    assign s_busy = cur ? busy2 : busy16;

    always #5 clk = ~clk;

    transmitter_datapath #(.CLKS_PER_BIT(16)) dut16 (
        .i_clock(clk), .i_reset(rst),
        .i_state_is_START(f16[0]), .i_state_is_DATA(f16[1]), .i_state_is_STOP(f16[2]),
        .i_data(d16), .o_equal(eq16), .o_equal_MSB(msb16), .o_tx(tx16), .o_busy(busy16));

    transmitter_datapath #(.CLKS_PER_BIT(2)) dut2 (
        .i_clock(clk), .i_reset(rst),
        .i_state_is_START(f2[0]), .i_state_is_DATA(f2[1]), .i_state_is_STOP(f2[2]),
        .i_data(d2), .o_equal(eq2), .o_equal_MSB(msb2), .o_tx(tx2), .o_busy(busy2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic set_flags(input logic [2:0] f);
        if (cur) f2 = f; else f16 = f;
    endtask

    task automatic set_data(input logic [7:0] d);
        if (cur) d2 = d; else d16 = d;
    endtask

    // Level the line should carry for frame clock t (0 .. 10*cpb-1).
    function automatic logic line_bit(input logic [7:0] b, input int t, input int cpb);
        int s;
        s = t / cpb;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    // Idle cycles: flags low, line must settle to 1 and busy to 0.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_flags(3'b000);
            @(negedge clk);
            chk("idle_tx", s_tx, last_tx);
            chk("idle_busy", s_busy, last_busy);
            chk("idle_eq", s_eq, 1'b0);
            chk("idle_msb", s_msb, 1'b0);
            last_tx = 1'b1; last_busy = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // One frame of byte b. i_data switches to alt at clock chg_t (if > 0).
    // If abort_t >= 0, reset is asserted asynchronously during that clock.
    task automatic frame(input logic [7:0] b, input logic [7:0] alt,
                         input int chg_t, input int abort_t);
        int cpb, s, n_eq, n_last;
        cpb = cur ? 2 : 16;
        n_eq = 0; n_last = 0;
        for (int t = 0; t < 10 * cpb; t++) begin
            s = t / cpb;
            set_flags(s == 0 ? 3'b001 : (s <= 8 ? 3'b010 : 3'b100));
            if (t == 0) set_data(b);
            if (chg_t > 0 && t == chg_t) set_data(alt);
            if (t == abort_t) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_tx", s_tx, 1'b1);
                chk("rst_busy", s_busy, 1'b0);
                chk("rst_eq", s_eq, 1'b0);
                chk("rst_msb", s_msb, 1'b0);
                set_flags(3'b000);
                @(posedge clk); #1;
                rst = 1'b0;
                last_tx = 1'b1; last_busy = 1'b0;
                idle(2 * cpb);
                return;
            end
            @(negedge clk);
            chk("eq", s_eq, (t % cpb) == cpb - 1);
            chk("msb", s_msb, s == 8);
            chk("tx", s_tx, last_tx);
            chk("busy", s_busy, last_busy);
            if (s_eq) n_eq++;
            if (s_eq && s_msb) n_last++;
            last_tx = line_bit(b, t, cpb); last_busy = 1'b1;
            @(posedge clk); #1;
        end
        chk("eq_pulses", n_eq, 10);
        chk("last_bit_pulses", n_last, 1);
    endtask

    initial begin
        logic [7:0] rb, ra;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx16", tx16, 1'b1);   chk("reset_busy16", busy16, 1'b0);
        chk("reset_eq16", eq16, 1'b0);   chk("reset_msb16", msb16, 1'b0);
        chk("reset_tx2", tx2, 1'b1);     chk("reset_busy2", busy2, 1'b0);
        chk("reset_eq2", eq2, 1'b0);     chk("reset_msb2", msb2, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // CLKS_PER_BIT = 16
        cur = 1'b0; last_tx = 1'b1; last_busy = 1'b0;
        idle(2);
        frame(8'hA5, 8'hA5, 0, -1);
        idle(3);
        frame(8'h00, 8'h00, 0, -1);            // back-to-back, no idle bit
        frame(8'hFF, 8'hFF, 0, -1);
        idle(2);
        frame(8'h3C, 8'hC3, 3 * 16 + 5, -1);   // data changes mid-DATA
        idle(1);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom); ra = 8'($urandom);
            frame(rb, ra, $urandom_range(1, 159), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(1);
        frame(8'h5A, 8'h5A, 0, 5 * 16 + 7);    // reset during data bit 4
        frame(8'h96, 8'h96, 0, $urandom_range(5 * 16, 9 * 16 - 1));
        frame(8'h96, 8'h96, 0, -1);             // clean frame after reset
        idle(2);

        // CLKS_PER_BIT = 2
        cur = 1'b1; last_tx = 1'b1; last_busy = 1'b0;
        idle(2);
        frame(8'h81, 8'h81, 0, -1);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom); ra = 8'($urandom);
            frame(rb, ra, $urandom_range(1, 19), -1);
        end
        idle(2);
        frame(8'hE7, 8'hE7, 0, 13);
        frame(8'h42, 8'h42, 0, -1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
